// File: rtl/examen_job_arbiter.sv
// Round-robin front end that shares one start/x -> y/error compute engine
// between NUM_REQ requesters, with a per-job timeout.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   req, req_x        per-requester request level and packed operand slots
//   grant, rsp_valid  one-hot single-cycle pulses to the winning requester
//   rsp_y, rsp_error, rsp_timeout  response payload, held until next response
//   busy              high whenever a job is in flight
//   eng_start, eng_x  launch pulse and operand towards the engine
//   eng_done, eng_y, eng_error     completion strobe and result from the engine
module examen_job_arbiter #(
  parameter int unsigned WORD_LENGTH    = 8,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] req_x,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [WORD_LENGTH-1:0]         rsp_y,
  output logic                           rsp_error,
  output logic                           rsp_timeout,
  output logic                           busy,
  output logic                           eng_start,
  output logic [WORD_LENGTH-1:0]         eng_x,
  input  logic                           eng_done,
  input  logic [WORD_LENGTH-1:0]         eng_y,
  input  logic                           eng_error
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                 state, state_d;
  logic [IDX_W-1:0]       sel, sel_d;
  logic [IDX_W-1:0]       last, last_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [WORD_LENGTH-1:0] eng_x_d;
  logic [NUM_REQ-1:0]     grant_d, rsp_valid_d;
  logic [WORD_LENGTH-1:0] rsp_y_d;
  logic                   rsp_error_d, rsp_timeout_d, eng_start_d, busy_d;

  logic [WORD_LENGTH-1:0] slot_x [NUM_REQ];
  logic [IDX_W-1:0]       winner, scan_idx;
  logic                   found;

  // Unpack the operand bus into per-requester slots
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot_x[i] = req_x[i*WORD_LENGTH +: WORD_LENGTH];
  end

  // Round-robin pick: first requester after the last served one, wrapping
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDX_W'((32'(last) + k) % NUM_REQ);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // Next state and next value of every registered output
  always_comb begin
    state_d       = state;
    sel_d         = sel;
    last_d        = last;
    cnt_d         = cnt;
    eng_x_d       = eng_x;
    grant_d       = '0;
    rsp_valid_d   = '0;
    eng_start_d   = 1'b0;
    rsp_y_d       = rsp_y;
    rsp_error_d   = rsp_error;
    rsp_timeout_d = rsp_timeout;

    unique case (state)
      S_IDLE: begin
        if (found) begin
          state_d     = S_LAUNCH;
          sel_d       = winner;
          eng_x_d     = slot_x[winner];
          grant_d     = NUM_REQ'(1) << winner;
          eng_start_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a simultaneous timeout expiry
        if (eng_done) begin
          rsp_y_d       = eng_y;
          rsp_error_d   = eng_error;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = NUM_REQ'(1) << sel;
          state_d       = S_RESP;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_y_d       = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = NUM_REQ'(1) << sel;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        last_d  = sel;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      sel         <= '0;
      last        <= IDX_W'(NUM_REQ - 1);
      cnt         <= '0;
      eng_x       <= '0;
      grant       <= '0;
      rsp_valid   <= '0;
      eng_start   <= 1'b0;
      rsp_y       <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      last        <= last_d;
      cnt         <= cnt_d;
      eng_x       <= eng_x_d;
      grant       <= grant_d;
      rsp_valid   <= rsp_valid_d;
      eng_start   <= eng_start_d;
      rsp_y       <= rsp_y_d;
      rsp_error   <= rsp_error_d;
      rsp_timeout <= rsp_timeout_d;
      busy        <= busy_d;
    end
  end

endmodule
